booth_seq_mult: RTL and testbench

//  Parametrised radix-2 Booth sequential multiplier. Successor to the fixed 16x16 datapath/controller pair.

---
 rtl/mult_pkg.sv | 15 +
 rtl/booth_step.sv | 29 ++
 rtl/booth_seq_mult.sv | 117 +++++++++++
 tb/tb_booth_seq_mult.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Counter width: must hold 0..WIDTH+1, since the count moves one past the last step.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: add/subtract M according to {Q[0],Q1},
// then arithmetic right shift of {A,Q,Q1} by one bit.
module booth_step #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] q,
    input  logic [W-1:0] m,
    input  logic         q1,
    output logic [W-1:0] a_next,
    output logic [W-1:0] q_next,
    output logic         q1_next
);

    logic [W-1:0] sum;

    // Booth recoding of the current bit pair, then shift with the sign of the new A replicated.
    always_comb begin
        case ({q[0], q1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_next  = {sum[W-1], sum[W-1:1]};
        q_next  = {sum[0], q[W-1:1]};
        q1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Parametrised radix-2 Booth sequential multiplier with valid/ready on both
// sides, per-operation signed/unsigned mode, output hold and synchronous abort.
module booth_seq_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned ITER = WIDTH + 1;
    localparam int unsigned W1   = WIDTH + 1;
    localparam int unsigned CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mult_state_t   state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W1-1:0] a_r, q_r, m_r;
    logic          q1_r;

    logic [W1-1:0] a_nxt, q_nxt;
    logic          q1_nxt;
    logic          accept, step, finish;

    booth_step #(.W(W1)) u_step (
        .a       (a_r),
        .q       (q_r),
        .m       (m_r),
        .q1      (q1_r),
        .a_next  (a_nxt),
        .q_next  (q_nxt),
        .q1_next (q1_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and datapath control; clear overrides every transition.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = CALC;
                    end
                end
                CALC: begin
                    step = 1'b1;
                    if (cnt == LAST) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake/status outputs decoded from the state register only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == CALC);
    end

    // Operand/accumulator registers, step counter and product register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            a_r     <= '0;
            q_r     <= '0;
            m_r     <= '0;
            q1_r    <= 1'b0;
            product <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt  <= '0;
            a_r  <= '0;
            q1_r <= 1'b0;
            m_r  <= {multiplicand[WIDTH-1] & in_signed, multiplicand};
            q_r  <= {multiplier[WIDTH-1] & in_signed, multiplier};
        end else if (step) begin
            a_r  <= a_nxt;
            q_r  <= q_nxt;
            q1_r <= q1_nxt;
            cnt  <= cnt + CW'(1);
            // Low 2*WIDTH bits of the final {A,Q}; the top two bits are sign extension.
            if (finish) product <= {a_nxt[WIDTH-2:0], q_nxt};
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and randomised checks of booth_seq_mult at WIDTH=16 and WIDTH=8.
`timescale 1ns/1ps
module tb_booth_seq_mult;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    // WIDTH=16 instance
    logic        in_valid, in_signed, out_ready;
    logic [15:0] mcand, mplier;
    logic        in_ready, out_valid, busy;
    logic [31:0] product;

    // WIDTH=8 instance
    logic        in_valid8, in_signed8, out_ready8;
    logic [7:0]  mcand8, mplier8;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] product8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .multiplicand(mcand), .multiplier(mplier),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_signed(in_signed8),
        .multiplicand(mcand8), .multiplier(mplier8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );

    // Drives one operation on the 16-bit DUT from IDLE and collects it.
    // lat counts clock edges from the accept edge (inclusive) to the first sample with out_valid=1.
    task automatic do_op16(input logic s, input logic [15:0] m, input logic [15:0] q,
                           output logic [31:0] p, output int lat);
        in_signed = s; mcand = m; mplier = q; in_valid = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
        p = product;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0;
        in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
        in_valid8 = 1'b0; in_signed8 = 1'b0; out_ready8 = 1'b0; mcand8 = '0; mplier8 = '0;
        #2;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++; $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, busy});
        end
        total++;
        if (product !== 32'h0) begin
            bad++; $display("FAIL reset_product16: got %h want 00000000", product);
        end
        total++;
        if ({in_ready8, out_valid8, busy8, product8} !== {3'b100, 16'h0}) begin
            bad++; $display("FAIL reset_dut8: got %b/%h want 100/0000", {in_ready8, out_valid8, busy8}, product8);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        logic [31:0] p; int lat;
        do_op16(1'b1, 16'hFFFD, 16'h0005, p, lat);
        total++;
        if (p !== 32'hFFFF_FFF1) begin bad++; $display("FAIL signed_m3x5: got %h want fffffff1", p); end
        total++;
        if (lat !== 18) begin bad++; $display("FAIL latency: got %0d want 18", lat); end
    endtask

    task automatic test_unsigned();
        logic [31:0] p; int lat;
        do_op16(1'b0, 16'hFFFF, 16'hFFFF, p, lat);
        total++;
        if (p !== 32'hFFFE_0001) begin bad++; $display("FAIL unsigned_ffff: got %h want fffe0001", p); end
        do_op16(1'b1, 16'hFFFF, 16'hFFFF, p, lat);
        total++;
        if (p !== 32'h0000_0001) begin bad++; $display("FAIL signed_ffff: got %h want 00000001", p); end
    endtask

    task automatic test_extremes();
        logic [31:0] p; int lat;
        do_op16(1'b1, 16'h8000, 16'h8000, p, lat);
        total++;
        if (p !== 32'h4000_0000) begin bad++; $display("FAIL signed_min_min: got %h want 40000000", p); end
        do_op16(1'b1, 16'h8000, 16'h7FFF, p, lat);
        total++;
        if (p !== 32'hC000_8000) begin bad++; $display("FAIL signed_min_max: got %h want c0008000", p); end
        do_op16(1'b0, 16'h8000, 16'h8000, p, lat);
        total++;
        if (p !== 32'h4000_0000) begin bad++; $display("FAIL unsigned_8000: got %h want 40000000", p); end
    endtask

    task automatic test_backpressure();
        int cyc;
        in_signed = 1'b0; mcand = 16'h0012; mplier = 16'h0034; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        // Offer a new operation while DONE is stalled; it must not be taken.
        in_valid = 1'b1; in_signed = 1'b1; mcand = 16'hFFFF; mplier = 16'h0002;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 32'h0000_03A8) begin
                bad++;
                $display("FAIL hold_cycle%0d: got ov=%b ir=%b p=%h want ov=1 ir=0 p=000003a8",
                         i, out_valid, in_ready, product);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL release_idle: got ir,ov=%b want 10", {in_ready, out_valid});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL accept_after_release: got busy=%b want 1", busy); end
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        total++;
        if (out_valid !== 1'b1 || product !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL second_op: got ov=%b p=%h want ov=1 p=fffffffe", out_valid, product);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] p; int lat; int highs;
        in_signed = 1'b0; mcand = 16'h1234; mplier = 16'h5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL clear_idle: got flags=%b p=%h want flags=100 p=fffffffe",
                     {in_ready, out_valid, busy}, product);
        end
        highs = 0;
        repeat (25) begin @(posedge clk); #1; if (out_valid) highs++; end
        total++;
        if (highs !== 0) begin bad++; $display("FAIL clear_no_result: got %0d valid cycles want 0", highs); end
        do_op16(1'b0, 16'd7, 16'd9, p, lat);
        total++;
        if (p !== 32'h0000_003F) begin bad++; $display("FAIL after_clear: got %h want 0000003f", p); end

        // Asynchronous reset in the middle of a calculation.
        in_signed = 1'b0; mcand = 16'h00FF; mplier = 16'h00FF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: got flags=%b p=%h want flags=100 p=00000000",
                     {in_ready, out_valid, busy}, product);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        do_op16(1'b1, 16'hFFF9, 16'd9, p, lat);
        total++;
        if (p !== 32'hFFFF_FFC1) begin bad++; $display("FAIL after_reset: got %h want ffffffc1", p); end
    endtask

    task automatic test_sweep16(input int nops);
        logic [15:0] m, q; logic s; logic [63:0] e; logic [31:0] got; int guard; bit done;
        for (int n = 0; n < nops; n++) begin
            m = 16'($urandom); q = 16'($urandom); s = n[0];
            if (s) e = 64'(longint'($signed(m)) * longint'($signed(q)));
            else   e = 64'(longint'(m) * longint'(q));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_signed = s; mcand = m; mplier = q; in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
            @(posedge clk); #1;
            done = 0; guard = 0; got = '0;
            while (!done && guard < 200) begin
                // Garbage operands with random valid must be ignored outside IDLE.
                in_valid = 1'($urandom_range(0, 1)); mcand = 16'($urandom); mplier = 16'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin got = product; done = 1; end
                @(posedge clk); #1;
                guard++;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            total++;
            if (!done || got !== e[31:0]) begin
                bad++;
                $display("FAIL sweep16 %h*%h s=%b: got %h want %h done=%0d", m, q, s, got, e[31:0], done);
            end
        end
    endtask

    task automatic test_sweep8(input int nops);
        logic [7:0] m, q; logic s; logic [63:0] e; logic [15:0] got; int guard; bit done;
        for (int n = 0; n < nops; n++) begin
            m = 8'($urandom); q = 8'($urandom); s = n[0];
            if (n < 4) begin m = 8'h80; q = (n < 2) ? 8'h80 : 8'h7F; end
            if (s) e = 64'(longint'($signed(m)) * longint'($signed(q)));
            else   e = 64'(longint'(m) * longint'(q));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_signed8 = s; mcand8 = m; mplier8 = q; in_valid8 = 1'b1;
            guard = 0;
            while (!in_ready8 && guard < 50) begin @(posedge clk); #1; guard++; end
            @(posedge clk); #1;
            done = 0; guard = 0; got = '0;
            while (!done && guard < 200) begin
                in_valid8 = 1'($urandom_range(0, 1)); mcand8 = 8'($urandom); mplier8 = 8'($urandom);
                out_ready8 = 1'($urandom_range(0, 1));
                if (out_valid8 && out_ready8) begin got = product8; done = 1; end
                @(posedge clk); #1;
                guard++;
            end
            in_valid8 = 1'b0; out_ready8 = 1'b0;
            total++;
            if (!done || got !== e[15:0]) begin
                bad++;
                $display("FAIL sweep8 %h*%h s=%b: got %h want %h done=%0d", m, q, s, got, e[15:0], done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_extremes();
        test_backpressure();
        test_abort();
        test_sweep16(500);
        test_sweep8(500);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
